// File: rtl/test_sequencer.sv
// test_sequencer: launches NUM_TESTS test channels sequentially or in parallel,
// guards them with a watchdog and aggregates pass/fail/timeout results.
module test_sequencer #(
  parameter int NUM_TESTS      = 18,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 8,
  parameter int IDX_W          = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  output logic [NUM_TESTS-1:0] test_start,
  input  logic [NUM_TESTS-1:0] test_done,
  input  logic [NUM_TESTS-1:0] test_pass,
  output logic                 busy,
  output logic                 all_done,
  output logic [IDX_W-1:0]     cur_test,
  output logic [CNT_W-1:0]     pass_count,
  output logic [CNT_W-1:0]     fail_count,
  output logic [CNT_W-1:0]     timeout_count,
  output logic [NUM_TESTS-1:0] fail_mask
);
  localparam logic [1:0] IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, FINISH = 2'd3;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  function automatic logic [6:0] pop(input logic [NUM_TESTS-1:0] v);
    pop = '0;
    for (int i = 0; i < NUM_TESTS; i++) pop = pop + 7'(v[i]);
  endfunction

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] a, input logic [6:0] b);
    logic [CNT_W+7:0] s;
    s = (CNT_W+8)'(a) + (CNT_W+8)'(b);
    sat = (s > (CNT_W+8)'({CNT_W{1'b1}})) ? '1 : s[CNT_W-1:0];
  endfunction

  logic [1:0]           state_q, state_d;
  logic                 mode_q, mode_d;
  logic [IDX_W-1:0]     cur_q, cur_d;
  logic [NUM_TESTS-1:0] pend_q, pend_d, mask_q, mask_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [CNT_W-1:0]     pass_q, pass_d, fail_q, fail_d, tmo_q, tmo_d;
  logic [NUM_TESTS-1:0] sel, act, hit, bad, to;
  logic                 expire, last;

  // In sequential mode only the current channel is live; in parallel every pending one is.
  assign sel    = NUM_TESTS'(1) << cur_q;
  assign act    = mode_q ? pend_q : sel;
  assign hit    = act & test_done;
  assign expire = (wd_q + 1'b1) == WD_W'(TIMEOUT_CYCLES);
  assign to     = expire ? (act & ~hit) : '0;
  assign bad    = (hit & ~test_pass) | to;
  assign last   = cur_q == IDX_W'(NUM_TESTS - 1);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    wd_d    = wd_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    tmo_d   = tmo_q;
    mask_d  = mask_q;
    if ((state_q == IDLE || state_q == FINISH) && start) begin
      mode_d  = mode;
      cur_d   = '0;
      pend_d  = '0;
      pass_d  = '0;
      fail_d  = '0;
      tmo_d   = '0;
      mask_d  = '0;
      state_d = LAUNCH;
    end else if (state_q == LAUNCH) begin
      wd_d    = '0;
      pend_d  = mode_q ? '1 : '0;
      state_d = WAIT;
    end else if (state_q == WAIT) begin
      wd_d   = wd_q + 1'b1;
      pass_d = sat(pass_q, pop(hit & test_pass));
      fail_d = sat(fail_q, pop(bad));
      tmo_d  = sat(tmo_q, pop(to));
      mask_d = mask_q | bad;
      if (mode_q) begin
        pend_d  = pend_q & ~hit & ~to;
        state_d = (expire || (pend_q & ~hit) == '0) ? FINISH : WAIT;
      end else if (|hit || expire) begin
        state_d = last ? FINISH : LAUNCH;
        cur_d   = last ? cur_q : cur_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      cur_q   <= '0;
      pend_q  <= '0;
      wd_q    <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      tmo_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      wd_q    <= wd_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      tmo_q   <= tmo_d;
      mask_q  <= mask_d;
    end
  end

  assign test_start    = (state_q == LAUNCH) ? (mode_q ? '1 : sel) : '0;
  assign busy          = state_q == LAUNCH || state_q == WAIT;
  assign all_done      = state_q == FINISH;
  assign cur_test      = cur_q;
  assign pass_count    = pass_q;
  assign fail_count    = fail_q;
  assign timeout_count = tmo_q;
  assign fail_mask     = mask_q;
endmodule
